bcd_seq_conv: RTL and testbench

Parametrised sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one iteration per clock. It extends the fixed 4-bit converter to any input width and digit count, and adds optional two's-complement input, an overflow flag and valid/ready handshakes on both sides. It sits between binary datapath results and the decimal display/readout logic.

---
 rtl/bcd_seq_conv_if.sv | 25 ++
 rtl/bcd_seq_conv.sv | 108 ++++++++++
 tb/tb_bcd_seq_conv.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_seq_conv_if.sv
// Handshake bundle for the sequential binary-to-BCD converter.
// The producer/consumer side uses master; the converter uses slave.
interface bcd_seq_conv_if #(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
);
    logic                    in_valid;
    logic                    in_ready;
    logic [BIN_W-1:0]        bin_in;
    logic                    out_valid;
    logic                    out_ready;
    logic [4*DIGITS-1:0]     dec_out;
    logic                    neg;
    logic                    ovf;

    modport master (
        output in_valid, bin_in, out_ready,
        input  in_ready, out_valid, dec_out, neg, ovf
    );

    modport slave (
        input  in_valid, bin_in, out_ready,
        output in_ready, out_valid, dec_out, neg, ovf
    );
endinterface

// File: rtl/bcd_seq_conv.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock,
// with optional two's-complement input, sticky overflow and valid/ready on both sides.
module bcd_seq_conv #(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3,
    parameter bit          SIGNED = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    bcd_seq_conv_if.slave bus
);
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t               r_state;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [BIN_W-1:0]     r_bin;
    logic [BCD_W-1:0]     r_bcd;
    logic [CNT_W-1:0]     r_i;
    logic                 r_neg;
    logic                 r_ovf;

    logic                 w_neg;
    logic [BIN_W-1:0]     w_mag;
    logic [BCD_W-1:0]     w_adj;
    logic [BCD_W-1:0]     w_bcd_next;
    logic [BIN_W-1:0]     w_bin_next;
    logic                 w_shift_out;
    logic                 w_last;

    // Magnitude capture: unsigned BIN_W wrap makes the most negative value convert correctly.
    always_comb begin
        w_neg = SIGNED && bus.bin_in[BIN_W-1];
        w_mag = w_neg ? BIN_W'(-bus.bin_in) : bus.bin_in;
    end

    // Per-digit add-3 (mod 16) followed by the combined left shift.
    always_comb begin
        w_adj = r_bcd;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
            end
        end
        w_shift_out = w_adj[BCD_W-1];
        w_bcd_next  = {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};
        w_bin_next  = {r_bin[BIN_W-2:0], 1'b0};
        w_last      = (r_i == CNT_W'(BIN_W - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_bin       <= '0;
            r_bcd       <= '0;
            r_i         <= '0;
            r_neg       <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_bin      <= w_mag;
                        r_neg      <= w_neg;
                        r_bcd      <= '0;
                        r_ovf      <= 1'b0;
                        r_i        <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_bcd <= w_bcd_next;
                    r_bin <= w_bin_next;
                    r_i   <= r_i + CNT_W'(1);
                    if (w_shift_out) begin
                        r_ovf <= 1'b1;
                    end
                    if (w_last) begin
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.dec_out   = r_bcd;
    assign bus.neg       = r_neg;
    assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_bcd_seq_conv.sv
// Bench for bcd_seq_conv: four configurations checked against a decimal-arithmetic model
// every cycle a result is presented, plus hand-computed literal expectations.
module tb_bcd_seq_conv;
    localparam int NI = 4;
    localparam int BW[NI] = '{8, 4, 8, 8};
    localparam int DG[NI] = '{3, 2, 3, 2};
    localparam int SG[NI] = '{0, 0, 1, 0};

    typedef struct {
        logic [11:0] d;
        logic        n;
        logic        o;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tv_valid[NI];
    logic        t_ordy[NI];
    logic [7:0]  tv_bin[NI];
    logic        w_irdy[NI];
    logic        w_ovld[NI];
    logic [11:0] w_dec[NI];
    logic        w_neg[NI];
    logic        w_ovf[NI];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   acc_cyc[NI];
    logic prev_ov[NI];
    exp_t q[NI][$];

    always #5 clk = ~clk;

    bcd_seq_conv_if #(.BIN_W(8), .DIGITS(3)) if0 ();
    bcd_seq_conv_if #(.BIN_W(4), .DIGITS(2)) if1 ();
    bcd_seq_conv_if #(.BIN_W(8), .DIGITS(3)) if2 ();
    bcd_seq_conv_if #(.BIN_W(8), .DIGITS(2)) if3 ();

    bcd_seq_conv #(.BIN_W(8), .DIGITS(3), .SIGNED(1'b0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    bcd_seq_conv #(.BIN_W(4), .DIGITS(2), .SIGNED(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    bcd_seq_conv #(.BIN_W(8), .DIGITS(3), .SIGNED(1'b1)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    bcd_seq_conv #(.BIN_W(8), .DIGITS(2), .SIGNED(1'b0)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    assign if0.in_valid = tv_valid[0];
    assign if0.bin_in   = tv_bin[0];
    assign if0.out_ready = t_ordy[0];
    assign w_irdy[0] = if0.in_ready;
    assign w_ovld[0] = if0.out_valid;
    assign w_dec[0]  = if0.dec_out;
    assign w_neg[0]  = if0.neg;
    assign w_ovf[0]  = if0.ovf;

    assign if1.in_valid = tv_valid[1];
    assign if1.bin_in   = tv_bin[1][3:0];
    assign if1.out_ready = t_ordy[1];
    assign w_irdy[1] = if1.in_ready;
    assign w_ovld[1] = if1.out_valid;
    assign w_dec[1]  = 12'(if1.dec_out);
    assign w_neg[1]  = if1.neg;
    assign w_ovf[1]  = if1.ovf;

    assign if2.in_valid = tv_valid[2];
    assign if2.bin_in   = tv_bin[2];
    assign if2.out_ready = t_ordy[2];
    assign w_irdy[2] = if2.in_ready;
    assign w_ovld[2] = if2.out_valid;
    assign w_dec[2]  = if2.dec_out;
    assign w_neg[2]  = if2.neg;
    assign w_ovf[2]  = if2.ovf;

    assign if3.in_valid = tv_valid[3];
    assign if3.bin_in   = tv_bin[3];
    assign if3.out_ready = t_ordy[3];
    assign w_irdy[3] = if3.in_ready;
    assign w_ovld[3] = if3.out_valid;
    assign w_dec[3]  = 12'(if3.dec_out);
    assign w_neg[3]  = if3.neg;
    assign w_ovf[3]  = if3.ovf;

    task automatic check(input string nm, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
        end
    endtask

    // Decimal model: magnitude from plain integer arithmetic, digits by division.
    function automatic exp_t model(input int idx, input logic [7:0] v);
        exp_t e;
        int   mag;
        int   lim;
        int   r;
        mag = int'(v) & ((1 << BW[idx]) - 1);
        e.n = 1'b0;
        if (SG[idx] != 0 && mag >= (1 << (BW[idx] - 1))) begin
            mag = (1 << BW[idx]) - mag;
            e.n = 1'b1;
        end
        lim = (DG[idx] == 3) ? 1000 : 100;
        e.o = (mag >= lim);
        r   = mag % lim;
        e.d = 12'(((r / 100) % 10) * 256 + ((r / 10) % 10) * 16 + (r % 10));
        return e;
    endfunction

    // Acceptance monitor: records the expected result and acceptance cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) q[i].delete();
        end else begin
            cyc++;
            for (int i = 0; i < NI; i++) begin
                if (tv_valid[i] && w_irdy[i]) begin
                    q[i].push_back(model(i, tv_bin[i]));
                    acc_cyc[i] = cyc;
                end
            end
        end
    end

    // Compare process: every cycle a result is presented it must match the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) prev_ov[i] = 1'b0;
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (w_ovld[i]) begin
                    if (!prev_ov[i])
                        check($sformatf("latency[%0d]", i), cyc - acc_cyc[i], BW[i]);
                    if (q[i].size() == 0) begin
                        check($sformatf("spurious_out_valid[%0d]", i), 1, 0);
                    end else begin
                        check($sformatf("dec[%0d]", i), int'(w_dec[i]), int'(q[i][0].d));
                        check($sformatf("neg[%0d]", i), int'(w_neg[i]), int'(q[i][0].n));
                        check($sformatf("ovf[%0d]", i), int'(w_ovf[i]), int'(q[i][0].o));
                        check($sformatf("in_ready_in_done[%0d]", i), int'(w_irdy[i]), 0);
                        if (t_ordy[i]) void'(q[i].pop_front());
                    end
                end
                prev_ov[i] = w_ovld[i];
            end
        end
    end

    // Drives one conversion, scrambles bin_in during SHIFT, returns the presented result.
    task automatic convert(input int idx, input logic [7:0] v,
                           output logic [11:0] d, output logic n, output logic o);
        int t;
        @(negedge clk);
        t = 0;
        while (!w_irdy[idx] && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (t >= 40) check($sformatf("accept_timeout[%0d]", idx), 1, 0);
        tv_valid[idx] = 1'b1;
        tv_bin[idx]   = v;
        @(negedge clk);
        tv_valid[idx] = 1'b0;
        tv_bin[idx]   = ~v;
        t = 0;
        while (!w_ovld[idx] && t < 40) begin
            @(negedge clk);
            t++;
            tv_bin[idx] = 8'($urandom);
        end
        if (t >= 40) check($sformatf("result_timeout[%0d]", idx), 1, 0);
        d = w_dec[idx];
        n = w_neg[idx];
        o = w_ovf[idx];
        if (t_ordy[idx]) @(negedge clk);
    endtask

    logic [11:0] d;
    logic        n;
    logic        o;

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            tv_valid[i] = 1'b0;
            tv_bin[i]   = 8'h00;
            t_ordy[i]   = 1'b1;
        end
        repeat (2) @(negedge clk);
        check("rst_in_ready", int'(w_irdy[0]), 1);
        check("rst_out_valid", int'(w_ovld[0]), 0);
        check("rst_dec", int'(w_dec[0]), 0);
        check("rst_neg_ovf", int'({w_neg[0], w_ovf[0]}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", int'(w_irdy[0]), 1);
        check("post_rst_out_valid", int'(w_ovld[0]), 0);

        convert(0, 8'd0, d, n, o);
        check("zero_dec", int'(d), 'h000);
        check("zero_ovf", int'(o), 0);

        convert(1, 8'd11, d, n, o);
        check("legacy_11", int'(d), 'h11);
        convert(1, 8'd15, d, n, o);
        check("legacy_15", int'(d), 'h15);

        for (int v = 0; v < 256; v++) begin
            convert(0, 8'(v), d, n, o);
            if (v == 255) check("sweep_255", int'(d), 'h255);
            if (v == 100) check("sweep_100", int'(d), 'h100);
            if (v == 99)  check("sweep_99", int'(d), 'h099);
        end

        // Backpressure: result must sit unchanged while out_ready is low.
        t_ordy[0] = 1'b0;
        convert(0, 8'd237, d, n, o);
        check("bp_dec", int'(d), 'h237);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_hold_dec", int'(w_dec[0]), 'h237);
            check("bp_hold_flags", int'({w_neg[0], w_ovf[0], w_ovld[0], w_irdy[0]}), 'b0010);
        end
        t_ordy[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_in_ready", int'(w_irdy[0]), 1);

        convert(2, 8'h80, d, n, o);
        check("s_80_dec", int'(d), 'h128);
        check("s_80_neg", int'(n), 1);
        convert(2, 8'hF5, d, n, o);
        check("s_F5_dec", int'(d), 'h011);
        check("s_F5_neg", int'(n), 1);
        convert(2, 8'h7F, d, n, o);
        check("s_7F_dec", int'(d), 'h127);
        check("s_7F_neg", int'(n), 0);
        convert(2, 8'hFF, d, n, o);
        check("s_FF_dec", int'(d), 'h001);

        convert(3, 8'd255, d, n, o);
        check("ovf_255_dec", int'(d), 'h55);
        check("ovf_255_flag", int'(o), 1);
        convert(3, 8'd99, d, n, o);
        check("ovf_99_dec", int'(d), 'h99);
        check("ovf_99_flag", int'(o), 0);
        convert(3, 8'd100, d, n, o);
        check("ovf_100_dec", int'(d), 'h00);
        check("ovf_100_flag", int'(o), 1);

        // Reset asserted during the 3rd SHIFT cycle must abort asynchronously.
        @(negedge clk);
        tv_valid[0] = 1'b1;
        tv_bin[0]   = 8'hFF;
        @(posedge clk);
        #1 tv_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_in_ready", int'(w_irdy[0]), 1);
        check("abort_out_valid", int'(w_ovld[0]), 0);
        check("abort_dec", int'(w_dec[0]), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            check("abort_no_out_valid", int'(w_ovld[0]), 0);
        end
        convert(0, 8'd42, d, n, o);
        check("after_abort_42", int'(d), 'h042);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
